mem_arbiter_rr: RTL and testbench

MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

---
 rtl/mem_arbiter_rr.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - round-robin arbiter serialising byte/half/word requests onto a byte-wide RAM port
//
// Purpose:
//   Grants one of NUM_PORTS requesters at a time (round-robin), then walks the
//   request one byte per cycle over a registered byte-wide RAM port. Loads are
//   reassembled little-endian and zero/sign-extended; stores to I/O space stall
//   while the I/O sink is full. A flush cancels loads only.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global clock enable (low freezes every register)
//   flush               cancel in-flight load; restricts new grants to stores
//   io_buffer_full      I/O sink cannot accept a byte this cycle
//   req_*               per-port request bundle, held until req_ready pulses
//   ram_din             RAM read byte for the address issued on the previous cycle
//   req_ready           one-cycle accept pulse (per port)
//   resp_valid          one-cycle completion pulse (per port)
//   resp_data, resp_id  load result / tag, zero outside the completion pulse
//   busy                transaction in progress
//   ram_dout/addr/wr    registered RAM byte port
module mem_arbiter_rr #(
  parameter int          NUM_PORTS  = 2,
  parameter int          ADDR_WIDTH = 32,
  parameter int          ID_WIDTH   = 4,
  parameter logic [31:0] IO_BASE    = 32'h30000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rdy,
  input  logic                            flush,
  input  logic                            io_buffer_full,
  input  logic [NUM_PORTS-1:0]            req_valid,
  input  logic [NUM_PORTS-1:0]            req_write,
  input  logic [2*NUM_PORTS-1:0]          req_size,
  input  logic [NUM_PORTS-1:0]            req_signed,
  input  logic [ADDR_WIDTH*NUM_PORTS-1:0] req_addr,
  input  logic [32*NUM_PORTS-1:0]         req_wdata,
  input  logic [ID_WIDTH*NUM_PORTS-1:0]   req_id,
  input  logic [7:0]                      ram_din,
  output logic [NUM_PORTS-1:0]            req_ready,
  output logic [NUM_PORTS-1:0]            resp_valid,
  output logic [31:0]                     resp_data,
  output logic [ID_WIDTH-1:0]             resp_id,
  output logic                            busy,
  output logic [7:0]                      ram_dout,
  output logic [ADDR_WIDTH-1:0]           ram_addr,
  output logic                            ram_wr
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [ADDR_WIDTH-1:0] IO_BASE_A = ADDR_WIDTH'(IO_BASE);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t                state;
  logic [PW-1:0]         last_q;    // last granted port; search starts after it
  logic [PW-1:0]         port_q;
  logic                  write_q;
  logic                  signed_q;
  logic [1:0]            size_q;
  logic [1:0]            idx_q;     // byte index currently presented on the RAM port
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           data_q;
  logic [ID_WIDTH-1:0]   id_q;

  function automatic logic [PW-1:0] rr_wrap(input logic [PW-1:0] base, input int off);
    int v;
    v = int'(base) + off;
    if (v >= NUM_PORTS) v = v - NUM_PORTS;
    return PW'(v);
  endfunction

  function automatic logic [1:0] last_byte(input logic [1:0] size);
    case (size)
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      default: return 2'd3;  // size 3 behaves as a word
    endcase
  endfunction

  // Round-robin pick; while flushing only stores are eligible.
  logic          grant_found;
  logic [PW-1:0] grant_port;
  logic [PW-1:0] cand;
  always_comb begin
    grant_found = 1'b0;
    grant_port  = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = rr_wrap(last_q, i);
      if (!grant_found && req_valid[cand] && (!flush || req_write[cand])) begin
        grant_found = 1'b1;
        grant_port  = cand;
      end
    end
  end

  logic                  g_write;
  logic                  g_signed;
  logic [1:0]            g_size;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [31:0]           g_wdata;
  logic [ID_WIDTH-1:0]   g_id;
  logic                  g_hold;
  assign g_write  = req_write[grant_port];
  assign g_signed = req_signed[grant_port];
  assign g_size   = req_size[grant_port*2 +: 2];
  assign g_addr   = req_addr[grant_port*ADDR_WIDTH +: ADDR_WIDTH];
  assign g_wdata  = req_wdata[grant_port*32 +: 32];
  assign g_id     = req_id[grant_port*ID_WIDTH +: ID_WIDTH];
  assign g_hold   = io_buffer_full && (g_addr >= IO_BASE_A);

  // Store progress: a byte counts as written only if ram_wr was high during
  // the cycle; a held byte is re-offered at the same index.
  logic [1:0]            st_idx;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic                  st_hold;
  assign st_idx  = ram_wr ? idx_q + 2'd1 : idx_q;
  assign st_addr = addr_q + ADDR_WIDTH'(st_idx);
  assign st_hold = io_buffer_full && (st_addr >= IO_BASE_A);

  // Load result including the byte arriving this cycle.
  logic [31:0] ld_word;
  logic [31:0] ld_result;
  always_comb begin
    ld_word = data_q;
    ld_word[8*idx_q +: 8] = ram_din;
    case (last_byte(size_q))
      2'd0:    ld_result = {{24{signed_q & ld_word[7]}}, ld_word[7:0]};
      2'd1:    ld_result = {{16{signed_q & ld_word[15]}}, ld_word[15:0]};
      default: ld_result = ld_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_q     <= PW'(NUM_PORTS - 1);
      port_q     <= '0;
      write_q    <= 1'b0;
      signed_q   <= 1'b0;
      size_q     <= 2'd0;
      idx_q      <= 2'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      id_q       <= '0;
      req_ready  <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_id    <= '0;
      busy       <= 1'b0;
      ram_dout   <= '0;
      ram_addr   <= '0;
      ram_wr     <= 1'b0;
    end else if (rdy) begin
      req_ready  <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_id    <= '0;
      case (state)
        // DONE is a one-cycle bubble that may already grant the next request.
        S_IDLE, S_DONE: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          ram_addr <= '0;
          ram_wr   <= 1'b0;
          if (grant_found) begin
            state                 <= S_XFER;
            busy                  <= 1'b1;
            last_q                <= grant_port;
            port_q                <= grant_port;
            req_ready[grant_port] <= 1'b1;
            write_q               <= g_write;
            signed_q              <= g_signed;
            size_q                <= g_size;
            addr_q                <= g_addr;
            wdata_q               <= g_wdata;
            id_q                  <= g_id;
            idx_q                 <= 2'd0;
            data_q                <= '0;
            ram_addr              <= g_addr;
            ram_wr                <= g_write && !g_hold;
            ram_dout              <= g_write ? g_wdata[7:0] : 8'h00;
          end
        end

        S_XFER: begin
          if (!write_q) begin
            if (flush) begin
              state    <= S_IDLE;
              busy     <= 1'b0;
              ram_addr <= '0;
            end else begin
              data_q[8*idx_q +: 8] <= ram_din;
              if (idx_q == last_byte(size_q)) begin
                state              <= S_DONE;
                ram_addr           <= '0;
                resp_valid[port_q] <= 1'b1;
                resp_data          <= ld_result;
                resp_id            <= id_q;
              end else begin
                idx_q    <= idx_q + 2'd1;
                ram_addr <= addr_q + ADDR_WIDTH'(idx_q + 2'd1);
              end
            end
          end else begin
            if (ram_wr && (idx_q == last_byte(size_q))) begin
              state              <= S_DONE;
              ram_wr             <= 1'b0;
              ram_addr           <= '0;
              resp_valid[port_q] <= 1'b1;
              resp_id            <= id_q;
            end else begin
              idx_q    <= st_idx;
              ram_addr <= st_addr;
              ram_wr   <= !st_hold;
              ram_dout <= wdata_q[8*st_idx +: 8];
            end
          end
        end

        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          ram_addr <= '0;
          ram_wr   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb/tb_mem_arbiter_rr.sv - self-checking bench for mem_arbiter_rr
module tb_mem_arbiter_rr;
  localparam int NP = 2;
  localparam int AW = 32;
  localparam int IW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic              flush;
  logic              io_buffer_full;
  logic [NP-1:0]     req_valid;
  logic [NP-1:0]     req_write;
  logic [2*NP-1:0]   req_size;
  logic [NP-1:0]     req_signed;
  logic [AW*NP-1:0]  req_addr;
  logic [32*NP-1:0]  req_wdata;
  logic [IW*NP-1:0]  req_id;
  logic [7:0]        ram_din;
  logic [NP-1:0]     req_ready;
  logic [NP-1:0]     resp_valid;
  logic [31:0]       resp_data;
  logic [IW-1:0]     resp_id;
  logic              busy;
  logic [7:0]        ram_dout;
  logic [AW-1:0]     ram_addr;
  logic              ram_wr;

  mem_arbiter_rr #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .IO_BASE(32'h30000)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .io_buffer_full(io_buffer_full),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_id(req_id), .ram_din(ram_din),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data), .resp_id(resp_id),
    .busy(busy), .ram_dout(ram_dout), .ram_addr(ram_addr), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  // 1 KiB byte RAM, aliased on the low address bits, combinational read.
  logic [7:0]    mem [0:1023];
  logic [AW-1:0] wlog_addr [$];
  logic [7:0]    wlog_data [$];
  assign ram_din = mem[ram_addr[9:0]];
  always @(posedge clk) begin
    if (ram_wr) begin
      mem[ram_addr[9:0]] = ram_dout;
      wlog_addr.push_back(ram_addr);
      wlog_data.push_back(ram_dout);
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_req(input int p, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [3:0] id);
    req_write[p]         = w;
    req_size[2*p +: 2]   = sz;
    req_signed[p]        = sg;
    req_addr[AW*p +: AW] = a;
    req_wdata[32*p +: 32] = wd;
    req_id[IW*p +: IW]   = id;
    req_valid[p]         = 1'b1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] bytes);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] ea;
      ea = a + 32'(k);
      mem[ea[9:0]] = bytes[8*k +: 8];
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (busy && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("drain_busy", busy, 0);
  endtask

  task automatic wait_resp(input int p, input int bound, output logic seen, output logic [31:0] data);
    seen = 1'b0;
    data = '0;
    for (int c = 0; c < bound && !seen; c++) begin
      @(negedge clk);
      if (resp_valid[p]) begin
        seen = 1'b1;
        data = resp_data;
      end
    end
  endtask

  task automatic count_resp(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (resp_valid != '0) n++;
    end
  endtask

  typedef struct {
    int          port;
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ram_bytes;
    logic [31:0] exp_data;
    int          nbytes;
    logic [3:0]  id;
  } vec_t;

  vec_t vecs [9];

  // Enters and leaves on a falling edge with the DUT idle.
  task automatic run_vec(input int vi, input vec_t v);
    string         tag;
    logic [NP-1:0] oh;
    logic [31:0]   ea;
    tag = $sformatf("v%0d", vi);
    oh  = NP'(1) << v.port;
    preload(v.addr, v.ram_bytes);
    wlog_addr.delete();
    wlog_data.delete();
    set_req(v.port, v.wr, v.sz, v.sg, v.addr, v.wdata, v.id);
    @(negedge clk);
    req_valid[v.port] = 1'b0;
    check({tag, "_ready"}, req_ready, oh);
    check({tag, "_busy"}, busy, 1);
    for (int k = 0; k < v.nbytes; k++) begin
      if (k > 0) @(negedge clk);
      ea = v.addr + 32'(k);
      check($sformatf("%s_addr%0d", tag, k), ram_addr, ea);
      check($sformatf("%s_wr%0d", tag, k), ram_wr, v.wr);
      if (v.wr) check($sformatf("%s_dout%0d", tag, k), ram_dout, v.wdata[8*k +: 8]);
    end
    @(negedge clk);
    check({tag, "_resp_valid"}, resp_valid, oh);
    check({tag, "_resp_data"}, resp_data, v.exp_data);
    check({tag, "_resp_id"}, resp_id, v.id);
    check({tag, "_done_addr"}, ram_addr, 0);
    check({tag, "_done_busy"}, busy, 1);
    if (v.wr) check({tag, "_nwrites"}, wlog_addr.size(), v.nbytes);
    @(negedge clk);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_resp"}, resp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        seen;
    logic [31:0] d;
    int          n;
    int          gports [$];
    int          gcyc [$];
    int          multi;

    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    req_valid = '0; req_write = '0; req_size = '0; req_signed = '0;
    req_addr = '0; req_wdata = '0; req_id = '0;

    vecs[0] = '{0, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,         32'h1234_5678, 32'h1234_5678, 4, 4'h3};
    vecs[1] = '{1, 1'b0, 2'd0, 1'b1, 32'h0000_0110, 32'h0,         32'h0000_0080, 32'hFFFF_FF80, 1, 4'h5};
    vecs[2] = '{0, 1'b0, 2'd1, 1'b0, 32'h0000_0120, 32'h0,         32'h0000_80FF, 32'h0000_80FF, 2, 4'h6};
    vecs[3] = '{1, 1'b0, 2'd0, 1'b0, 32'h0000_0131, 32'h0,         32'h0000_0080, 32'h0000_0080, 1, 4'h7};
    vecs[4] = '{0, 1'b0, 2'd1, 1'b1, 32'h0000_0142, 32'h0,         32'h0000_9234, 32'hFFFF_9234, 2, 4'h8};
    vecs[5] = '{1, 1'b0, 2'd3, 1'b0, 32'h0000_0150, 32'h0,         32'h0403_0201, 32'h0403_0201, 4, 4'h9};
    vecs[6] = '{1, 1'b1, 2'd2, 1'b0, 32'h0000_0200, 32'hAABB_CCDD, 32'h0,         32'h0,         4, 4'hA};
    vecs[7] = '{0, 1'b1, 2'd1, 1'b0, 32'h0000_0211, 32'h1234_5678, 32'h0,         32'h0,         2, 4'hB};
    vecs[8] = '{0, 1'b0, 2'd2, 1'b1, 32'hFFFF_FFFF, 32'h0,         32'h8899_AABB, 32'h8899_AABB, 4, 4'hC};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ram_wr", ram_wr, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_dout", ram_dout, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_id", resp_id, 0);
    rst = 1'b0;

    // Continuous requests on both ports: 0 first, then alternating, one grant at a time
    preload(32'h100, 32'h1234_5678);
    set_req(0, 1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 4'h1);
    set_req(1, 1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 4'h2);
    multi = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if ($countones(req_ready) > 1) multi++;
      if (req_ready[0]) begin gports.push_back(0); gcyc.push_back(c); end
      else if (req_ready[1]) begin gports.push_back(1); gcyc.push_back(c); end
    end
    req_valid = '0;
    check("rr_onehot", multi, 0);
    check("rr_ngrants", gports.size(), 6);
    for (int i = 0; i < 4; i++)
      check($sformatf("rr_order%0d", i), (i < gports.size()) ? gports[i] : -1, i % 2);
    check("rr_gap", (gcyc.size() > 1) ? gcyc[1] - gcyc[0] : -1, 2);
    drain();

    // Table of single transactions
    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Store survives a flush pulse mid-transfer
    wlog_addr.delete(); wlog_data.delete();
    set_req(0, 1'b1, 2'd2, 1'b0, 32'h200, 32'hAABB_CCDD, 4'h1);
    @(negedge clk); req_valid[0] = 1'b0;
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    wait_resp(0, 8, seen, d);
    check("stflush_resp", seen, 1);
    check("stflush_nwr", wlog_addr.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("stflush_wa%0d", k), (k < wlog_addr.size()) ? wlog_addr[k] : 32'hx, 32'h200 + 32'(k));
      check($sformatf("stflush_wd%0d", k), (k < wlog_data.size()) ? wlog_data[k] : 8'hx,
            (k == 0) ? 8'hDD : (k == 1) ? 8'hCC : (k == 2) ? 8'hBB : 8'hAA);
    end
    drain();

    // Load aborted by flush at byte 2
    preload(32'h100, 32'h1234_5678);
    set_req(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 4'h2);
    @(negedge clk); req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ldflush_addr2", ram_addr, 32'h102);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("ldflush_busy", busy, 0);
    check("ldflush_ram_addr", ram_addr, 0);
    check("ldflush_resp", resp_valid, 0);
    count_resp(6, n);
    check("ldflush_no_resp", n, 0);

    // I/O store stalled three cycles by a full sink
    wlog_addr.delete(); wlog_data.delete();
    io_buffer_full = 1'b1;
    set_req(0, 1'b1, 2'd0, 1'b0, 32'h30000, 32'h0000_005A, 4'h4);
    @(negedge clk); req_valid[0] = 1'b0;
    check("io_stall0", ram_wr, 0);
    @(negedge clk);
    check("io_stall1", ram_wr, 0);
    check("io_stall_addr", ram_addr, 32'h30000);
    @(negedge clk);
    check("io_stall2", ram_wr, 0);
    io_buffer_full = 1'b0;
    @(negedge clk);
    check("io_go_wr", ram_wr, 1);
    check("io_go_dout", ram_dout, 8'h5A);
    check("io_go_addr", ram_addr, 32'h30000);
    @(negedge clk);
    check("io_resp", resp_valid, 2'b01);
    check("io_nwr", wlog_addr.size(), 1);
    check("io_wdata", (wlog_data.size() > 0) ? wlog_data[0] : 8'hx, 8'h5A);
    drain();

    // Just below IO_BASE a full sink does not stall
    io_buffer_full = 1'b1;
    set_req(0, 1'b1, 2'd0, 1'b0, 32'h2FFFF, 32'h0000_0011, 4'h5);
    @(negedge clk); req_valid[0] = 1'b0;
    check("io_below_wr", ram_wr, 1);
    @(negedge clk);
    check("io_below_resp", resp_valid, 2'b01);
    io_buffer_full = 1'b0;
    drain();

    // rdy low freezes a load mid-transfer
    preload(32'h100, 32'h1234_5678);
    set_req(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 4'h6);
    @(negedge clk); req_valid[1] = 1'b0;
    @(negedge clk);
    rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("frz_addr%0d", c), ram_addr, 32'h101);
    end
    rdy = 1'b1;
    wait_resp(1, 6, seen, d);
    check("frz_resp", seen, 1);
    check("frz_data", d, 32'h1234_5678);
    drain();

    // Reset at byte 1 of a load
    set_req(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 4'h7);
    @(negedge clk); req_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_busy", busy, 0);
    check("rstmid_wr", ram_wr, 0);
    check("rstmid_resp", resp_valid, 0);
    count_resp(5, n);
    check("rstmid_no_resp", n, 0);

    // Flush in idle grants only stores
    flush = 1'b1;
    set_req(0, 1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 4'h1);
    set_req(1, 1'b1, 2'd0, 1'b0, 32'h220, 32'h0000_0033, 4'h2);
    @(negedge clk);
    check("fidle_store_grant", req_ready, 2'b10);
    req_valid[1] = 1'b0;
    n = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (req_ready[0]) n++;
    end
    check("fidle_no_load_grant", n, 0);
    flush = 1'b0;
    @(negedge clk);
    check("fidle_load_grant", req_ready, 2'b01);
    req_valid[0] = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
